// File: rtl/bomberman_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bomberman_pkg
// Brief    : Shared direction/state encodings, blocked-bit indices, tile size
//            and play-area bounds for the Bomberman movement block.
// Revision : 1.0 - initial release
// ============================================================================
package bomberman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } state_e;

  localparam int BLK_LEFT  = 0;
  localparam int BLK_RIGHT = 1;
  localparam int BLK_UP    = 2;
  localparam int BLK_DOWN  = 3;

  localparam int TILE_SIZE  = 16;
  localparam int POS_W      = 10;
  localparam int PLAY_X_MIN = 48;
  localparam int PLAY_X_MAX = 560;
  localparam int PLAY_Y_MIN = 32;
  localparam int PLAY_Y_MAX = 448;

  // Fixed priority up > down > left > right; keeps the current facing if idle.
  function automatic dir_e pick_dir(input logic up, input logic down,
                                    input logic left, input logic right,
                                    input dir_e cur);
    if (up)    return DIR_UP;
    if (down)  return DIR_DOWN;
    if (left)  return DIR_LEFT;
    if (right) return DIR_RIGHT;
    return cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : step_tick_gen
// Brief    : Free-running 0..STEP_DIV-1 counter while enabled; one-cycle tick
//            on the terminal count, cleared whenever disabled.
// Revision : 1.0 - initial release
// ============================================================================
module step_tick_gen #(
  parameter int STEP_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bomberman_move.sv
`default_nettype none
// ============================================================================
// Module   : bomberman_move
// Brief    : IDLE/WALK movement FSM for the Bomberman sprite with clamped,
//            blockable one-pixel steps. Macro BOMBERMAN_ANIM_EN enables the
//            walk animation frame counter (anim_frame is 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module bomberman_move
  import bomberman_pkg::*;
#(
  parameter int STEP_DIV = 1000000,
  parameter int X_MIN    = PLAY_X_MIN,
  parameter int X_MAX    = PLAY_X_MAX,
  parameter int Y_MIN    = PLAY_Y_MIN,
  parameter int Y_MAX    = PLAY_Y_MAX,
  parameter int START_X  = PLAY_X_MIN,
  parameter int START_Y  = PLAY_Y_MIN,
  parameter int ANIM_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic [3:0]       bomberman_blocked,
  output logic [POS_W-1:0] b_x,
  output logic [POS_W-1:0] b_y,
  output logic [1:0]       dir,
  output logic             walking,
  output logic [1:0]       anim_frame
);

  localparam logic [POS_W-1:0] XMIN_C = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] XMAX_C = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YMIN_C = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0] YMAX_C = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] ONE_C  = POS_W'(1);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [POS_W-1:0] bx_q, bx_d, by_q, by_d;
  logic             any_btn;
  logic             step_tick;

  assign any_btn = btn_l | btn_r | btn_u | btn_d;

  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_step_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_WALK),
    .tick   (step_tick)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    bx_d    = bx_q;
    by_d    = by_q;
    if (any_btn) dir_d = pick_dir(btn_u, btn_d, btn_l, btn_r, dir_q);
    case (state_q)
      ST_IDLE: if (any_btn)  state_d = ST_WALK;
      ST_WALK: if (!any_btn) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The step uses the facing that was registered during the tick cycle.
    if (step_tick) begin
      case (dir_q)
        DIR_UP:    if (!bomberman_blocked[BLK_UP]    && by_q > YMIN_C) by_d = by_q - ONE_C;
        DIR_DOWN:  if (!bomberman_blocked[BLK_DOWN]  && by_q < YMAX_C) by_d = by_q + ONE_C;
        DIR_LEFT:  if (!bomberman_blocked[BLK_LEFT]  && bx_q > XMIN_C) bx_d = bx_q - ONE_C;
        DIR_RIGHT: if (!bomberman_blocked[BLK_RIGHT] && bx_q < XMAX_C) bx_d = bx_q + ONE_C;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_DOWN;
      bx_q    <= POS_W'(START_X);
      by_q    <= POS_W'(START_Y);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
    end
  end

  assign b_x     = bx_q;
  assign b_y     = by_q;
  assign dir     = dir_q;
  assign walking = (state_q == ST_WALK);

`ifdef BOMBERMAN_ANIM_EN
  localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [ACW-1:0] ACNT_MAX = ACW'(ANIM_DIV - 1);

  logic [ACW-1:0] acnt_q, acnt_d;
  logic [1:0]     frame_q, frame_d;
  logic           step_ok, enter_idle;

  // A step is successful exactly when the position actually changes.
  assign step_ok    = (bx_d != bx_q) || (by_d != by_q);
  assign enter_idle = (state_q == ST_WALK) && (state_d == ST_IDLE);

  always_comb begin
    acnt_d  = acnt_q;
    frame_d = frame_q;
    if (enter_idle) begin
      acnt_d  = '0;
      frame_d = '0;
    end else if (step_ok) begin
      if (acnt_q == ACNT_MAX) begin
        acnt_d  = '0;
        frame_d = frame_q + 2'd1;
      end else begin
        acnt_d = acnt_q + ACW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acnt_q  <= '0;
      frame_q <= '0;
    end else begin
      acnt_q  <= acnt_d;
      frame_q <= frame_d;
    end
  end

  assign anim_frame = frame_q;
`else
  // ANIM_DIV stays on the interface so both builds share one parameter list.
  if (ANIM_DIV < 1) begin : g_anim_div_unused
  end
  assign anim_frame = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bomberman_move.sv
`default_nettype none
// ============================================================================
// Module   : tb_bomberman_move
// Brief    : Directed scoreboard bench for bomberman_move (STEP_DIV=4,
//            ANIM_DIV=2); anim expectations follow BOMBERMAN_ANIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bomberman_move;

`ifdef BOMBERMAN_ANIM_EN
  localparam bit ANIM_ON = 1'b1;
`else
  localparam bit ANIM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic [3:0] blocked = 4'b0000;
  logic [9:0] b_x, b_y;
  logic [1:0] dir;
  logic       walking;
  logic [1:0] anim_frame;

  always #5 clk = ~clk;

  bomberman_move #(.STEP_DIV(4), .ANIM_DIV(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_l             (btn_l),
    .btn_r             (btn_r),
    .btn_u             (btn_u),
    .btn_d             (btn_d),
    .bomberman_blocked (blocked),
    .b_x               (b_x),
    .b_y               (b_y),
    .dir               (dir),
    .walking           (walking),
    .anim_frame        (anim_frame)
  );

  typedef struct {
    string      name;
    logic [9:0] bx;
    logic [9:0] by;
    logic [1:0] dr;
    logic       walk;
    logic [1:0] anim;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: one expectation is consumed per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (b_x !== e.bx || b_y !== e.by || dir !== e.dr ||
          walking !== e.walk || anim_frame !== e.anim) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d dir=%0d walk=%0b anim=%0d, want x=%0d y=%0d dir=%0d walk=%0b anim=%0d",
                 e.name, b_x, b_y, dir, walking, anim_frame,
                 e.bx, e.by, e.dr, e.walk, e.anim);
      end
    end
  end

  function automatic logic [1:0] af(input logic [1:0] v);
    return ANIM_ON ? v : 2'd0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int bx, input int by,
                     input int dr, input bit walk, input logic [1:0] anim);
    exp_t e;
    e.name = name;
    e.bx   = 10'(bx);
    e.by   = 10'(by);
    e.dr   = 2'(dr);
    e.walk = walk;
    e.anim = anim;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
    blocked = 4'b0000;
    reset   = 1'b0;
    step(2);
    reset   = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // Walk right: steps land on the edge after each 4th WALK cycle.
    do_reset();
    chk("reset_state", 48, 32, 1, 1'b0, 2'd0);
    btn_r = 1'b1;
    step(4);
    chk("r_before_tick", 48, 32, 3, 1'b1, 2'd0);
    step(1);
    chk("r_step1", 49, 32, 3, 1'b1, 2'd0);
    step(3);
    chk("r_held8", 49, 32, 3, 1'b1, 2'd0);
    btn_r = 1'b0;
    step(1);
    chk("r_step2_idle", 50, 32, 3, 1'b0, 2'd0);

    // Left against X_MIN: clamped, no animation.
    do_reset();
    btn_l = 1'b1;
    step(12);
    chk("l_bound_12", 48, 32, 2, 1'b1, 2'd0);
    step(1);
    chk("l_bound_13", 48, 32, 2, 1'b1, 2'd0);
    btn_l = 1'b0;

    // Down while blocked, then unblocked on the tick cycle.
    do_reset();
    btn_d   = 1'b1;
    blocked = 4'b1000;
    step(8);
    chk("d_blocked", 48, 32, 1, 1'b1, 2'd0);
    blocked = 4'b0000;
    step(1);
    chk("d_unblocked", 48, 33, 1, 1'b1, 2'd0);
    btn_d = 1'b0;
    step(1);
    chk("d_release", 48, 33, 1, 1'b0, 2'd0);

    // Priority and release behaviour.
    do_reset();
    btn_u = 1'b1;
    btn_r = 1'b1;
    step(1);
    chk("ur_prio", 48, 32, 0, 1'b1, 2'd0);
    {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
    step(1);
    chk("ur_release", 48, 32, 0, 1'b0, 2'd0);
    btn_d = 1'b1; btn_l = 1'b1; btn_r = 1'b1;
    step(1);
    chk("dlr_prio", 48, 32, 1, 1'b1, 2'd0);
    btn_d = 1'b0;
    step(1);
    chk("lr_prio_walk", 48, 32, 2, 1'b1, 2'd0);
    {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
    step(1);
    chk("lr_release", 48, 32, 2, 1'b0, 2'd0);
    btn_u = 1'b1; btn_d = 1'b1;
    step(1);
    chk("ud_prio", 48, 32, 0, 1'b1, 2'd0);
    {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
    step(1);

    // Direction change inside WALK keeps the step counter running.
    do_reset();
    btn_r = 1'b1;
    step(3);
    chk("turn_pre", 48, 32, 3, 1'b1, 2'd0);
    btn_r = 1'b0;
    btn_d = 1'b1;
    step(2);
    chk("turn_no_clear", 48, 33, 1, 1'b1, 2'd0);
    btn_d = 1'b0;
    step(1);

    // Animation over 4 successful steps.
    do_reset();
    btn_r = 1'b1;
    step(9);
    chk("anim_step2", 50, 32, 3, 1'b1, af(2'd1));
    step(8);
    chk("anim_step4", 52, 32, 3, 1'b1, af(2'd2));
    btn_r = 1'b0;
    step(1);
    chk("anim_idle_clear", 52, 32, 3, 1'b0, 2'd0);

    // Asynchronous reset mid-walk, then no step on the first edge after release.
    do_reset();
    btn_r = 1'b1;
    step(9);
    chk("pre_rst", 50, 32, 3, 1'b1, af(2'd1));
    step(1);
    reset = 1'b0;
    chk("rst_async", 48, 32, 1, 1'b0, 2'd0);
    reset = 1'b1;
    step(1);
    chk("rst_release_edge", 48, 32, 3, 1'b1, 2'd0);
    step(4);
    chk("rst_first_step", 49, 32, 3, 1'b1, 2'd0);
    btn_r = 1'b0;

    // Right against X_MAX: 512 steps then clamped.
    do_reset();
    btn_r = 1'b1;
    step(2052);
    chk("r_reach_max", 560, 32, 3, 1'b1, 2'd0);
    step(8);
    chk("r_clamp_max", 560, 32, 3, 1'b1, 2'd0);
    btn_r = 1'b0;
    step(1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
